// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [31:0] PC_INC  = 32'd4;

  typedef enum logic [2:0] {
    S_INIT,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_e;

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-unit bus: instruction-memory read port plus the instruction stream
// handed to the consumer. master = fetch unit, slave = memory/consumer side.
interface ifetch_unit_if;
  import ifetch_pkg::*;

  logic               imem_req;
  logic [31:0]        imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  logic               instr_valid;
  logic [INSTR_W-1:0] instr_out;
  logic [31:0]        instr_pc;
  logic               instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instr_out, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_out, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready
  );

endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: drives an external PC register, issues one read at
// a time, holds the returned instruction until the consumer takes it, and
// handles branch redirects (including discarding stale responses).
// Optional macro IFETCH_MISALIGN_TRAP_EN: misaligned redirect targets are
// rejected and flagged instead of being force-aligned.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         pc_q,
  output logic [31:0]         pc_d,
  output logic                pc_we,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  output logic                fetch_misaligned,
  ifetch_unit_if.master       bus
);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] instr_out_q, instr_out_d;
  logic [31:0]        instr_pc_q, instr_pc_d;

  logic               redir_take;
  logic [31:0]        redir_tgt;
  logic               pc_we_c;
  logic [31:0]        pc_d_c;
  logic               req_c;
  logic               valid_c;

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic mis_q, mis_d;
`endif

  // Next-state, holding-register and combinational output decode.
  always_comb begin
    state_d     = state_q;
    instr_out_d = instr_out_q;
    instr_pc_d  = instr_pc_q;
    pc_we_c     = 1'b0;
    pc_d_c      = pc_q;
    req_c       = 1'b0;
    valid_c     = 1'b0;
    redir_tgt   = redirect_pc & ~32'h3;
`ifdef IFETCH_MISALIGN_TRAP_EN
    // A rejected (misaligned) redirect is treated as if no redirect arrived.
    redir_take  = redirect_valid && (redirect_pc[1:0] == 2'b00);
    mis_d       = redirect_valid && (redirect_pc[1:0] != 2'b00) && (state_q != S_INIT);
`else
    redir_take  = redirect_valid;
`endif

    case (state_q)
      S_INIT: begin
        pc_we_c = 1'b1;
        pc_d_c  = RESET_PC;
        state_d = S_REQ;
      end
      S_REQ: begin
        req_c = 1'b1;
        if (redir_take) begin
          pc_we_c = 1'b1;
          pc_d_c  = redir_tgt;
          state_d = bus.imem_gnt ? S_DRAIN : S_REQ;
        end else if (bus.imem_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redir_take) begin
          pc_we_c = 1'b1;
          pc_d_c  = redir_tgt;
          state_d = bus.imem_rvalid ? S_REQ : S_DRAIN;
        end else if (bus.imem_rvalid) begin
          instr_out_d = bus.imem_rdata;
          instr_pc_d  = pc_q;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redir_take) begin
          pc_we_c = 1'b1;
          pc_d_c  = redir_tgt;
          state_d = S_REQ;
        end else begin
          valid_c = 1'b1;
          if (bus.instr_ready) begin
            pc_we_c = 1'b1;
            pc_d_c  = pc_q + PC_INC;
            state_d = S_REQ;
          end
        end
      end
      S_DRAIN: begin
        if (redir_take) begin
          pc_we_c = 1'b1;
          pc_d_c  = redir_tgt;
        end
        // The response in flight consumes the drain even if a redirect lands
        // in the same cycle; otherwise the unit would wait for nothing.
        if (bus.imem_rvalid) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // State and holding registers; reset restarts the fetch sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      instr_out_q <= '0;
      instr_pc_q  <= '0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      mis_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      instr_out_q <= instr_out_d;
      instr_pc_q  <= instr_pc_d;
`ifdef IFETCH_MISALIGN_TRAP_EN
      mis_q       <= mis_d;
`endif
    end
  end

  // INIT is the reset state, so the PC write strobe is gated off while in reset.
  assign pc_we           = pc_we_c & rst_n;
  assign pc_d            = rst_n ? pc_d_c : RESET_PC;
  assign bus.imem_req    = req_c;
  assign bus.imem_addr   = req_c ? pc_q : '0;
  assign bus.instr_valid = valid_c;
  assign bus.instr_out   = instr_out_q;
  assign bus.instr_pc    = instr_pc_q;

`ifdef IFETCH_MISALIGN_TRAP_EN
  assign fetch_misaligned = mis_q;
`else
  assign fetch_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios with literal expectations, then
// randomized memory/consumer/redirect traffic checked every cycle against a
// transaction-level model (outstanding request, held instruction, PC).
module tb_ifetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_reg = 32'hDEAD_BEEC;
  logic [31:0] pc_d;
  logic        pc_we;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fetch_misaligned;

  ifetch_unit_if bus();

  ifetch_unit #(.RESET_PC(RPC)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pc_q             (pc_reg),
    .pc_d             (pc_d),
    .pc_we            (pc_we),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .fetch_misaligned (fetch_misaligned),
    .bus              (bus)
  );

  always #5 clk = ~clk;

  // External PC register.
  always @(posedge clk) if (pc_we) pc_reg <= pc_d;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Model state
  bit          m_init, m_out, m_want, m_hold, m_mis;
  logic [31:0] m_addr, h_instr, h_pc;
  bit          mem_pending;
  int unsigned mem_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  task automatic model_reset();
    m_init = 1; m_out = 0; m_want = 0; m_hold = 0; m_mis = 0;
    mem_pending = 0; mem_cnt = 0;
  endtask

  // Compare DUT against the model for the current cycle, then advance the model.
  task automatic check_cycle();
    logic r_take, misal, e_req, e_valid, e_we;
    logic [31:0] e_pcd, e_addr;
    misal = redirect_valid && (redirect_pc[1:0] != 2'b00);
`ifdef IFETCH_MISALIGN_TRAP_EN
    r_take = redirect_valid && !misal;
`else
    r_take = redirect_valid;
`endif
    if (m_init) begin
      e_we = 1; e_pcd = RPC; e_req = 0; e_valid = 0;
    end else begin
      e_req   = !m_hold && !m_out;
      e_valid = m_hold && !r_take;
      if (r_take) begin
        e_we = 1; e_pcd = {redirect_pc[31:2], 2'b00};
      end else if (m_hold && bus.instr_ready) begin
        e_we = 1; e_pcd = pc_reg + 32'd4;
      end else begin
        e_we = 0; e_pcd = pc_reg;
      end
    end
    e_addr = e_req ? pc_reg : 32'h0;
    chk("pc_we", {31'b0, pc_we}, {31'b0, e_we});
    chk("pc_d", pc_d, e_pcd);
    chk("imem_req", {31'b0, bus.imem_req}, {31'b0, e_req});
    chk("imem_addr", bus.imem_addr, e_addr);
    chk("instr_valid", {31'b0, bus.instr_valid}, {31'b0, e_valid});
    chk("fetch_misaligned", {31'b0, fetch_misaligned}, {31'b0, m_mis});
    if (e_valid) begin
      chk("instr_out", bus.instr_out, h_instr);
      chk("instr_pc", bus.instr_pc, h_pc);
    end
    if (m_init) begin
      m_init = 0; m_mis = 0;
    end else begin
`ifdef IFETCH_MISALIGN_TRAP_EN
      m_mis = misal;
`else
      m_mis = 0;
`endif
      if (m_hold && (r_take || bus.instr_ready)) m_hold = 0;
      if (m_out && bus.imem_rvalid) begin
        m_out = 0;
        if (m_want && !r_take) begin
          m_hold = 1; h_instr = bus.imem_rdata; h_pc = m_addr;
        end
      end else if (m_out && r_take) begin
        m_want = 0;
      end
      if (e_req && bus.imem_gnt) begin
        m_out = 1; m_want = !r_take; m_addr = pc_reg;
      end
    end
    if (bus.imem_rvalid) mem_pending = 0;
    if (bus.imem_req && bus.imem_gnt) begin
      mem_pending = 1; mem_cnt = $urandom_range(0, 2);
    end
  endtask

  // Drive one cycle of inputs just after the edge, check at the falling edge.
  task automatic step(input logic g, input logic rv, input logic [31:0] rd,
                      input logic rdy, input logic rr, input logic [31:0] rp);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.imem_gnt = g; bus.imem_rvalid = rv; bus.imem_rdata = rd;
    bus.instr_ready = rdy; redirect_valid = rr; redirect_pc = rp;
    @(negedge clk);
    check_cycle();
  endtask

  task automatic do_reset(input int unsigned n);
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = 32'hA5A5_A5A5;
    bus.instr_ready = 0; redirect_valid = 0; redirect_pc = '0;
    model_reset();
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst pc_we", {31'b0, pc_we}, 32'h0);
      chk("rst pc_d", pc_d, RPC);
      chk("rst imem_req", {31'b0, bus.imem_req}, 32'h0);
      chk("rst imem_addr", bus.imem_addr, 32'h0);
      chk("rst instr_valid", {31'b0, bus.instr_valid}, 32'h0);
      chk("rst instr_out", bus.instr_out, 32'h0);
      chk("rst instr_pc", bus.instr_pc, 32'h0);
      chk("rst fetch_misaligned", {31'b0, fetch_misaligned}, 32'h0);
    end
  endtask

  initial begin
    logic        g, rv, rdy, rr;
    logic [31:0] rd, rp, r;

    bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = '0; bus.instr_ready = 0;
    do_reset(3);

    // Reset release: one PC load to RESET_PC, then fetch from it.
    step(0, 0, 0, 0, 0, 0);
    chk("init pc_we", {31'b0, pc_we}, 32'h1);
    chk("init pc_d", pc_d, 32'h0000_0100);
    step(1, 0, 0, 0, 0, 0);
    chk("first addr", bus.imem_addr, 32'h0000_0100);
    step(0, 1, 32'h0050_0093, 0, 0, 0);
    // Consumer stalls for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 32'hFFFF_0000, 0, 0, 0);
      chk("stall valid", {31'b0, bus.instr_valid}, 32'h1);
      chk("stall instr", bus.instr_out, 32'h0050_0093);
      chk("stall pc", bus.instr_pc, 32'h0000_0100);
      chk("stall pc_we", {31'b0, pc_we}, 32'h0);
    end
    step(0, 0, 0, 1, 0, 0);
    chk("accept pc_d", pc_d, 32'h0000_0104);
    step(1, 0, 0, 0, 0, 0);
    chk("second addr", bus.imem_addr, 32'h0000_0104);
    // Redirect while waiting: late response must be dropped.
    step(0, 0, 0, 0, 1, 32'h0000_0200);
    chk("wait redir pc_d", pc_d, 32'h0000_0200);
    step(0, 0, 0, 1, 0, 0);
    chk("drain no req", {31'b0, bus.imem_req}, 32'h0);
    step(0, 1, 32'hDEAD_BEEF, 1, 0, 0);
    chk("drain no valid", {31'b0, bus.instr_valid}, 32'h0);
    step(0, 0, 0, 0, 0, 0);
    chk("post drain addr", bus.imem_addr, 32'h0000_0200);
    // PC wraparound.
    step(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    step(1, 0, 0, 0, 0, 0);
    chk("wrap addr", bus.imem_addr, 32'hFFFF_FFFC);
    step(0, 1, 32'h1234_5678, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("wrap pc_d", pc_d, 32'h0000_0000);
    // Misaligned redirect target.
    step(0, 0, 0, 0, 1, 32'h0000_0202);
`ifdef IFETCH_MISALIGN_TRAP_EN
    chk("misal pc_we", {31'b0, pc_we}, 32'h0);
    step(1, 0, 0, 0, 0, 0);
    chk("misal flag", {31'b0, fetch_misaligned}, 32'h1);
`else
    chk("misal pc_d", pc_d, 32'h0000_0200);
    step(1, 0, 0, 0, 0, 0);
    chk("misal flag", {31'b0, fetch_misaligned}, 32'h0);
`endif
    step(0, 1, 32'h0BAD_F00D, 0, 0, 0);
    // Redirect beats ready in HOLD.
    step(0, 0, 0, 1, 1, 32'h0000_0300);
    chk("redir hold valid", {31'b0, bus.instr_valid}, 32'h0);
    chk("redir hold pc_d", pc_d, 32'h0000_0300);

    // Randomized traffic, with one reset mid-stream.
    do_reset(2);
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset(2);
      g   = ($urandom_range(0, 9) < 6);
      rdy = ($urandom_range(0, 9) < 6);
      rv  = mem_pending && (mem_cnt == 0);
      if (mem_pending && mem_cnt > 0) mem_cnt--;
      rd  = $urandom;
      rr  = ($urandom_range(0, 7) == 0);
      r   = $urandom;
      case ($urandom_range(0, 7))
        0:       rp = 32'hFFFF_FFFC;
        1:       rp = r;
        default: rp = r & ~32'h3;
      endcase
      step(g, rv, rd, rdy, rr, rp);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
